// File: rtl/apb_master_bridge_pkg.sv
// Shared widths, FSM encoding and helpers for the APB master bridge.
// Replaces the old parameters.vh header contents for this block.
package apb_master_bridge_pkg;

  localparam int unsigned ADDR_WIDTH             = 32;
  localparam int unsigned DATA_WIDTH             = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    MST_IDLE   = 2'b00,
    MST_SETUP  = 2'b01,
    MST_ACCESS = 2'b10,
    MST_RESP   = 2'b11
  } mst_state_e;

  // Read data is only returned for successful reads; writes and errors report zero.
  function automatic logic [DATA_WIDTH-1:0] rsp_data(
    input logic                  write,
    input logic                  slverr,
    input logic [DATA_WIDTH-1:0] prdata
  );
    return (!write && !slverr) ? prdata : '0;
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Host command/response channel to APB master converter, one transfer outstanding,
// with a PREADY timeout so a hung slave cannot stall the host.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TO_CNT_W       = 5
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR_m_s,
  output logic                  PWRITE_m_s,
  output logic                  PSEL_m_s,
  output logic                  PENABLE_m_s,
  output logic [DATA_WIDTH-1:0] PWDATA_m_s,
  input  logic                  PREADY_s_m,
  input  logic                  PSLVERR_s_m,
  input  logic [DATA_WIDTH-1:0] PRDATA_s_m
);

  localparam logic                to_en    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_W-1:0] to_limit = TO_CNT_W'(TIMEOUT_CYCLES);

  mst_state_e          state;
  logic [TO_CNT_W-1:0] to_cnt;
  logic [TO_CNT_W-1:0] to_cnt_inc;

  always_comb begin
    to_cnt_inc = to_cnt + TO_CNT_W'(1);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= MST_IDLE;
      to_cnt      <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      PADDR_m_s   <= '0;
      PWRITE_m_s  <= 1'b0;
      PSEL_m_s    <= 1'b0;
      PENABLE_m_s <= 1'b0;
      PWDATA_m_s  <= '0;
    end else begin
      unique case (state)
        MST_IDLE: begin
          cmd_ready <= 1'b1;
          // cmd_ready is registered, so the first IDLE cycle after reset cannot accept.
          if (cmd_valid && cmd_ready) begin
            PADDR_m_s   <= cmd_addr;
            PWRITE_m_s  <= cmd_write;
            PWDATA_m_s  <= cmd_wdata;
            PSEL_m_s    <= 1'b1;
            PENABLE_m_s <= 1'b0;
            cmd_ready   <= 1'b0;
            state       <= MST_SETUP;
          end
        end

        MST_SETUP: begin
          PENABLE_m_s <= 1'b1;
          to_cnt      <= '0;
          state       <= MST_ACCESS;
        end

        MST_ACCESS: begin
          if (PREADY_s_m) begin
            PSEL_m_s    <= 1'b0;
            PENABLE_m_s <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR_s_m;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= rsp_data(PWRITE_m_s, PSLVERR_s_m, PRDATA_s_m);
            state       <= MST_RESP;
          end else begin
            to_cnt <= to_cnt_inc;
            // Compare the incremented value so the abort lands on the edge ending
            // the TIMEOUT_CYCLES-th ACCESS cycle.
            if (to_en && (to_cnt_inc == to_limit)) begin
              PSEL_m_s    <= 1'b0;
              PENABLE_m_s <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
              state       <= MST_RESP;
            end
          end
        end

        MST_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            cmd_ready   <= 1'b1;
            state       <= MST_IDLE;
          end
        end

        default: state <= MST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB slave model, transaction-level reference model
// with a per-cycle compare process, plus directed host commands.
module tb_apb_master_bridge;
  import apb_master_bridge_pkg::*;

  localparam int          TO       = 16;
  localparam logic [31:0] MAX_ADDR = 32'h0000_003F;

  logic                  PCLK;
  logic                  PRESET;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] PADDR_m_s;
  logic                  PWRITE_m_s;
  logic                  PSEL_m_s;
  logic                  PENABLE_m_s;
  logic [DATA_WIDTH-1:0] PWDATA_m_s;
  logic                  PREADY_s_m;
  logic                  PSLVERR_s_m;
  logic [DATA_WIDTH-1:0] PRDATA_s_m;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(5)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR_m_s(PADDR_m_s), .PWRITE_m_s(PWRITE_m_s), .PSEL_m_s(PSEL_m_s),
    .PENABLE_m_s(PENABLE_m_s), .PWDATA_m_s(PWDATA_m_s),
    .PREADY_s_m(PREADY_s_m), .PSLVERR_s_m(PSLVERR_s_m), .PRDATA_s_m(PRDATA_s_m)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Slave model: ready after wait_cfg ACCESS cycles; noise on the bus outside ACCESS.
  int          wait_cfg;
  int          acc_cnt;
  logic        noise;
  logic [31:0] mem [64];
  logic        in_range;

  assign in_range    = (PADDR_m_s <= MAX_ADDR);
  assign PREADY_s_m  = PENABLE_m_s ? (PSEL_m_s && (acc_cnt == wait_cfg)) : noise;
  assign PSLVERR_s_m = PENABLE_m_s ? (PREADY_s_m && !in_range) : noise;
  assign PRDATA_s_m  = (PENABLE_m_s && PREADY_s_m && in_range) ? mem[PADDR_m_s[5:0]] : 32'hBAD0_BAD0;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) acc_cnt <= 0;
    else if (PSEL_m_s && PENABLE_m_s && !PREADY_s_m) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_ff @(posedge PCLK) begin
    if (PSEL_m_s && PENABLE_m_s && PREADY_s_m && PWRITE_m_s && in_range)
      mem[PADDR_m_s[5:0]] <= PWDATA_m_s;
  end

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] exp_mem [logic [31:0]];
  logic        outstanding;
  int          t;
  int          k;
  logic        ew;
  logic [31:0] ea;
  logic [31:0] ed;
  logic        exp_err;
  logic        exp_to;
  logic [31:0] exp_rd;
  int          n_acc;
  logic        had_xfer;
  logic        prev_psel;
  int          low_run;
  logic        last_err;
  logic        last_to;
  logic [31:0] last_rd;
  int          last_acc;

  task automatic mon_step();
    if (PRESET) begin
      outstanding = 1'b0;
      had_xfer    = 1'b0;
      prev_psel   = 1'b0;
      low_run     = 0;
      return;
    end
    if (PSEL_m_s) begin
      if (!prev_psel && had_xfer) chk("psel_gap", 32'(low_run >= 2), 32'd1);
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_psel = PSEL_m_s;

    if (!outstanding) begin
      chk("idle_psel",      32'(PSEL_m_s),    32'd0);
      chk("idle_penable",   32'(PENABLE_m_s), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid),   32'd0);
      chk("idle_rsp_err",   32'(rsp_err),     32'd0);
      chk("idle_rsp_to",    32'(rsp_timeout), 32'd0);
      chk("idle_rsp_rdata", rsp_rdata,        32'd0);
      chk("idle_cmd_ready", 32'(cmd_ready),   32'd1);
      if (cmd_valid) begin
        outstanding = 1'b1;
        t     = 0;
        n_acc = 0;
        ew    = cmd_write;
        ea    = cmd_addr;
        ed    = cmd_wdata;
        k      = (wait_cfg + 1 <= TO) ? wait_cfg + 1 : TO;
        exp_to = (wait_cfg + 1 > TO);
        if (exp_to) begin
          exp_err = 1'b1; exp_rd = '0;
        end else if (ea > MAX_ADDR) begin
          exp_err = 1'b1; exp_rd = '0;
        end else begin
          exp_err = 1'b0;
          exp_rd  = (!ew && exp_mem.exists(ea)) ? exp_mem[ea] : '0;
        end
      end
    end else begin
      t++;
      if (PSEL_m_s && PENABLE_m_s) n_acc++;
      chk("paddr",     PADDR_m_s,         ea);
      chk("pwrite",    32'(PWRITE_m_s),   32'(ew));
      chk("pwdata",    PWDATA_m_s,        ed);
      chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      if (t == 1) begin
        chk("setup_psel",    32'(PSEL_m_s),    32'd1);
        chk("setup_penable", 32'(PENABLE_m_s), 32'd0);
        chk("setup_rsp_valid", 32'(rsp_valid), 32'd0);
      end else if (t <= k + 1) begin
        chk("access_psel",    32'(PSEL_m_s),    32'd1);
        chk("access_penable", 32'(PENABLE_m_s), 32'd1);
        chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        chk("resp_psel",    32'(PSEL_m_s),    32'd0);
        chk("resp_penable", 32'(PENABLE_m_s), 32'd0);
        chk("rsp_valid",    32'(rsp_valid),   32'd1);
        chk("rsp_err",      32'(rsp_err),     32'(exp_err));
        chk("rsp_timeout",  32'(rsp_timeout), 32'(exp_to));
        chk("rsp_rdata",    rsp_rdata,        exp_rd);
        if (rsp_ready) begin
          last_err = rsp_err;
          last_to  = rsp_timeout;
          last_rd  = rsp_rdata;
          last_acc = n_acc;
          had_xfer = 1'b1;
          if (ew && !exp_err) exp_mem[ea] = ed;
          outstanding = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready),   32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid),   32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),     32'd0);
    chk({tag, "_rsp_to"},    32'(rsp_timeout), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata,        32'd0);
    chk({tag, "_paddr"},     PADDR_m_s,        32'd0);
    chk({tag, "_pwrite"},    32'(PWRITE_m_s),  32'd0);
    chk({tag, "_psel"},      32'(PSEL_m_s),    32'd0);
    chk({tag, "_penable"},   32'(PENABLE_m_s), 32'd0);
    chk({tag, "_pwdata"},    PWDATA_m_s,       32'd0);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input int wt);
    int n;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    wait_cfg  = wt;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge PCLK);
    while (!cmd_ready && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    chk("rsp_arrives", 32'(rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp(input int delay);
    wait_rsp();
    repeat (delay) begin
      @(posedge PCLK);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int wt);
    issue(w, a, d, wt);
    cmd_valid = 1'b0;
    finish_rsp(0);
  endtask

  initial begin
    checks = 0; errors = 0;
    PRESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; wait_cfg = 0; noise = 1'b1;
    outstanding = 1'b0; had_xfer = 1'b0; prev_psel = 1'b0; low_run = 0;
    last_err = 1'b0; last_to = 1'b0; last_rd = '0; last_acc = 0;
    fork
      forever begin
        @(negedge PCLK);
        mon_step();
      end
    join_none

    #2 PRESET = 1'b1;
    #1 check_all_zero("reset");
    @(negedge PCLK); #1 PRESET = 1'b0;
    @(posedge PCLK); #1;

    xfer(1'b1, 32'h10, 32'h0000_00A5, 0);
    chk("wr_err", 32'(last_err), 32'd0);
    chk("wr_rdata", last_rd, 32'd0);
    chk("wr_acc_cycles", 32'(last_acc), 32'd1);

    xfer(1'b0, 32'h10, 32'h0000_1234, 2);
    chk("rd_rdata", last_rd, 32'h0000_00A5);
    chk("rd_err", 32'(last_err), 32'd0);
    chk("rd_timeout", 32'(last_to), 32'd0);
    chk("rd_acc_cycles", 32'(last_acc), 32'd3);

    xfer(1'b0, 32'h100, 32'h0, 1);
    chk("oor_rd_err", 32'(last_err), 32'd1);
    chk("oor_rd_to", 32'(last_to), 32'd0);
    chk("oor_rd_rdata", last_rd, 32'd0);

    xfer(1'b1, 32'h104, 32'hFFFF_FFFF, 0);
    chk("oor_wr_err", 32'(last_err), 32'd1);

    xfer(1'b0, 32'h10, 32'h0, 15);
    chk("ready_at_limit_to", 32'(last_to), 32'd0);
    chk("ready_at_limit_rdata", last_rd, 32'h0000_00A5);
    chk("ready_at_limit_acc", 32'(last_acc), 32'd16);

    xfer(1'b0, 32'h10, 32'h0, 16);
    chk("to_err", 32'(last_err), 32'd1);
    chk("to_flag", 32'(last_to), 32'd1);
    chk("to_acc", 32'(last_acc), 32'd16);

    xfer(1'b1, 32'h14, 32'h0000_0033, 1000);
    chk("hang_to", 32'(last_to), 32'd1);
    chk("hang_rdata", last_rd, 32'd0);

    // Backpressure with the next command already waiting.
    issue(1'b0, 32'h10, 32'h0, 0);
    cmd_valid = 1'b0;
    wait_rsp();
    cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h0000_005A; cmd_valid = 1'b1;
    finish_rsp(5);
    chk("bp_rdata", last_rd, 32'h0000_00A5);
    issue(1'b1, 32'h20, 32'h0000_005A, 0);
    cmd_valid = 1'b0;
    finish_rsp(0);
    xfer(1'b0, 32'h20, 32'h0, 0);
    chk("bp_readback", last_rd, 32'h0000_005A);

    // Reset pulse in the middle of ACCESS.
    issue(1'b1, 32'h30, 32'h0000_0077, 8);
    cmd_valid = 1'b0;
    repeat (2) @(posedge PCLK);
    chk("pre_reset_penable", 32'(PENABLE_m_s), 32'd1);
    #3 PRESET = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge PCLK); #1 PRESET = 1'b0;
    @(posedge PCLK); #1;
    chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    xfer(1'b1, 32'h30, 32'h0000_0099, 1);
    chk("post_rst_wr_err", 32'(last_err), 32'd0);
    xfer(1'b0, 32'h30, 32'h0, 0);
    chk("post_rst_rdata", last_rd, 32'h0000_0099);

    repeat (3) @(posedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
